dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 147 ++++++++++++++
 tb/tb_dmem_responder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data memory responder: word-organised store with byte-lane writes and range checking.
// Latency: loads valid 1+WAIT_CYCLES cycles after acceptance; store ack the cycle after the strobe.
// Backpressure: loads are accepted only in IDLE/RESP (ignored while waiting); stores are never stalled.
// Optional: define DMEM_FWD_EN to forward a same-edge store into a same-word load.
module dmem_responder #(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dmem_read_ready,
  input  logic [31:0] dmem_read_address,
  input  logic        dmem_write_ready,
  input  logic [31:0] dmem_write_address,
  input  logic [31:0] dmem_write_data,
  input  logic [3:0]  dmem_write_byte,
  output logic [31:0] dmem_read_data,
  output logic        dmem_read_valid,
  output logic        dmem_write_valid,
  output logic        dmem_error
);

  localparam int DEPTH = 1 << (ADDR_WIDTH - 2);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [31:0] mem_q [DEPTH];

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] data_q, data_d;
  logic        rd_err_q, rd_err_d;
  logic        wr_vld_q, wr_err_q;

  logic [ADDR_WIDTH-3:0] rd_idx, wr_idx;
  logic                  rd_oor, wr_oor;
  logic                  rd_accept;
  logic                  wr_en;
  logic [31:0]           rd_word;

  // Byte offset bits are dropped: all accesses are whole-word internally.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, dmem_read_address[1:0], dmem_write_address[1:0]};

  assign rd_idx = dmem_read_address[ADDR_WIDTH-1:2];
  assign wr_idx = dmem_write_address[ADDR_WIDTH-1:2];
  assign rd_oor = |dmem_read_address[31:ADDR_WIDTH];
  assign wr_oor = |dmem_write_address[31:ADDR_WIDTH];

  assign rd_accept = dmem_read_ready && ((state_q == S_IDLE) || (state_q == S_RESP));
  assign wr_en     = dmem_write_ready && !wr_oor && !reset;

`ifdef DMEM_FWD_EN
  logic [31:0] lane_mask;
  assign lane_mask = {{8{dmem_write_byte[3]}}, {8{dmem_write_byte[2]}},
                      {8{dmem_write_byte[1]}}, {8{dmem_write_byte[0]}}};

  // Same-word store at the same edge: merge enabled store lanes over the stored word.
  always_comb begin
    rd_word = mem_q[rd_idx];
    if (dmem_write_ready && !wr_oor && (wr_idx == rd_idx)) begin
      rd_word = (mem_q[rd_idx] & ~lane_mask) | (dmem_write_data & lane_mask);
    end
  end
`else
  // Without forwarding a same-edge load sees the word as it was before the store.
  assign rd_word = mem_q[rd_idx];
`endif

  // Load FSM next-state: capture on acceptance, count wait states, then respond.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    rd_err_d = rd_err_q;
    case (state_q)
      S_IDLE, S_RESP: begin
        if (rd_accept) begin
          data_d   = rd_oor ? 32'h0 : rd_word;
          rd_err_d = rd_oor;
          if (WAIT_CYCLES == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Load FSM and captured-word registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      data_q   <= 32'h0;
      rd_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      rd_err_q <= rd_err_d;
    end
  end

  // Store acknowledge and store-error flag, one cycle after the strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_vld_q <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      wr_vld_q <= dmem_write_ready;
      wr_err_q <= dmem_write_ready && wr_oor;
    end
  end

  // Backing store: lane-enabled writes; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (dmem_write_byte[i]) begin
          mem_q[wr_idx][8*i +: 8] <= dmem_write_data[8*i +: 8];
        end
      end
    end
  end

  assign dmem_read_valid  = (state_q == S_RESP);
  assign dmem_read_data   = data_q;
  assign dmem_write_valid = wr_vld_q;
  assign dmem_error       = (dmem_read_valid && rd_err_q) || wr_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: vector table on a zero-wait instance,
// plus hand sequences for reset, wait states and reset during an in-flight load.
module tb_dmem_responder;

  logic        clk;
  logic        reset;
  logic        rd;
  logic [31:0] raddr;
  logic        wr;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic [3:0]  be;

  logic [31:0] rdata0, rdata3;
  logic        rvld0, rvld3, wvld0, wvld3, err0, err3;

  int pass_cnt = 0;
  int total_cnt = 0;

`ifdef DMEM_FWD_EN
  localparam logic [31:0] HAZ_EXP = 32'h12345678;
`else
  localparam logic [31:0] HAZ_EXP = 32'h00000000;
`endif

  dmem_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .reset(reset),
    .dmem_read_ready(rd), .dmem_read_address(raddr),
    .dmem_write_ready(wr), .dmem_write_address(waddr),
    .dmem_write_data(wdata), .dmem_write_byte(be),
    .dmem_read_data(rdata0), .dmem_read_valid(rvld0),
    .dmem_write_valid(wvld0), .dmem_error(err0)
  );

  dmem_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(3)) u3 (
    .clk(clk), .reset(reset),
    .dmem_read_ready(rd), .dmem_read_address(raddr),
    .dmem_write_ready(wr), .dmem_write_address(waddr),
    .dmem_write_data(wdata), .dmem_write_byte(be),
    .dmem_read_data(rdata3), .dmem_read_valid(rvld3),
    .dmem_write_valid(wvld3), .dmem_error(err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rd;
    logic [31:0] raddr;
    logic        wr;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        e_rvld;
    logic [31:0] e_rdata;
    logic        e_wvld;
    logic        e_err;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic set_in(input logic r, input logic [31:0] ra, input logic w,
                        input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] b);
    rd = r; raddr = ra; wr = w; waddr = wa; wdata = wd; be = b;
  endtask

  task automatic check_u0(input string nm, input logic ervld, input logic [31:0] erdata,
                          input logic ewvld, input logic eerr, input logic cmp_data);
    chk({nm, ".rvld"}, {31'b0, rvld0}, {31'b0, ervld});
    if (cmp_data) chk({nm, ".rdata"}, rdata0, erdata);
    chk({nm, ".wvld"}, {31'b0, wvld0}, {31'b0, ewvld});
    chk({nm, ".err"}, {31'b0, err0}, {31'b0, eerr});
  endtask

  task automatic add(input string n, input logic r, input logic [31:0] ra, input logic w,
                     input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] b,
                     input logic ev, input logic [31:0] ed, input logic ew, input logic ee);
    vec_t v;
    v.name = n; v.rd = r; v.raddr = ra; v.wr = w; v.waddr = wa; v.wdata = wd; v.be = b;
    v.e_rvld = ev; v.e_rdata = ed; v.e_wvld = ew; v.e_err = ee;
    tbl.push_back(v);
  endtask

  initial begin
    //    name          rd raddr          wr waddr          wdata          be       rvld rdata          wvld err
    add("st_full",      0, 32'h0,         1, 32'h10,        32'hDEADBEEF, 4'hF,    0, 32'h0,         1, 0);
    add("st_w0",        0, 32'h0,         1, 32'h0,         32'hCAFEF00D, 4'hF,    0, 32'h0,         1, 0);
    add("st_w20",       0, 32'h0,         1, 32'h20,        32'h00000000, 4'hF,    0, 32'h0,         1, 0);
    add("ld_full",      1, 32'h10,        0, 32'h0,         32'h0,        4'h0,    1, 32'hDEADBEEF,  0, 0);
    add("st_lane1",     0, 32'h0,         1, 32'h10,        32'h0000AB00, 4'b0010, 0, 32'h0,         1, 0);
    add("ld_merge_off", 1, 32'h13,        0, 32'h0,         32'h0,        4'h0,    1, 32'hDEADABEF,  0, 0);
    add("ld_b2b",       1, 32'h10,        0, 32'h0,         32'h0,        4'h0,    1, 32'hDEADABEF,  0, 0);
    add("st_be0",       0, 32'h0,         1, 32'h10,        32'hFFFFFFFF, 4'h0,    0, 32'h0,         1, 0);
    add("ld_after_be0", 1, 32'h10,        0, 32'h0,         32'h0,        4'h0,    1, 32'hDEADABEF,  0, 0);
    add("hazard",       1, 32'h20,        1, 32'h20,        32'h12345678, 4'hF,    1, HAZ_EXP,       1, 0);
    add("ld_post_haz",  1, 32'h20,        0, 32'h0,         32'h0,        4'h0,    1, 32'h12345678,  0, 0);
    add("ld_oor",       1, 32'h1000,      0, 32'h0,         32'h0,        4'h0,    1, 32'h0,         0, 1);
    add("st_oor",       0, 32'h0,         1, 32'h1000,      32'h55555555, 4'hF,    0, 32'h0,         1, 1);
    add("ld_w0_kept",   1, 32'h0,         0, 32'h0,         32'h0,        4'h0,    1, 32'hCAFEF00D,  0, 0);
    add("both_oor",     1, 32'h1000,      1, 32'h1004,      32'h77777777, 4'hF,    1, 32'h0,         1, 1);
    add("ld_oor_hi",    1, 32'h80000010,  0, 32'h0,         32'h0,        4'h0,    1, 32'h0,         0, 1);
    add("rd_wr_diff",   1, 32'h10,        1, 32'h24,        32'hA5A5A5A5, 4'hF,    1, 32'hDEADABEF,  1, 0);
    add("ld_w24",       1, 32'h24,        0, 32'h0,         32'h0,        4'h0,    1, 32'hA5A5A5A5,  0, 0);
    add("idle",         0, 32'h0,         0, 32'h0,         32'h0,        4'h0,    0, 32'h0,         0, 0);

    // Reset held two cycles with a load request pending: everything reads zero.
    reset = 1'b1;
    set_in(1, 32'h10, 0, 32'h0, 32'h0, 4'h0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check_u0($sformatf("rst%0d", k), 0, 32'h0, 0, 0, 1);
      chk($sformatf("rst%0d.u3rvld", k), {31'b0, rvld3}, 32'h0);
    end
    @(negedge clk);
    reset = 1'b0;
    set_in(0, 32'h0, 0, 32'h0, 32'h0, 4'h0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("post_rst%0d.rvld", k), {31'b0, rvld0}, 32'h0);
      @(negedge clk);
    end

    // Vector table against the zero-wait instance.
    foreach (tbl[i]) begin
      set_in(tbl[i].rd, tbl[i].raddr, tbl[i].wr, tbl[i].waddr, tbl[i].wdata, tbl[i].be);
      @(posedge clk); #1;
      check_u0(tbl[i].name, tbl[i].e_rvld, tbl[i].e_rdata, tbl[i].e_wvld, tbl[i].e_err,
               tbl[i].e_rvld);
      @(negedge clk);
    end

    // Let the wait-state instance drain.
    set_in(0, 32'h0, 0, 32'h0, 32'h0, 4'h0);
    repeat (6) @(negedge clk);

    // Wait states: request held four cycles, one response four cycles after acceptance.
    set_in(1, 32'h10, 0, 32'h0, 32'h0, 4'h0);
    for (int k = 1; k <= 9; k++) begin
      if (k == 5) rd = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("wait_e%0d.rvld", k), {31'b0, rvld3}, (k == 4) ? 32'h1 : 32'h0);
      if (k == 4) begin
        chk("wait.rdata", rdata3, 32'hDEADABEF);
        chk("wait.err", {31'b0, err3}, 32'h0);
      end
      @(negedge clk);
    end

    // Reset while loads are in flight and a store is presented.
    set_in(1, 32'h10, 0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    reset = 1'b1;
    set_in(1, 32'h10, 1, 32'h10, 32'h0, 4'hF);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check_u0($sformatf("midrst%0d", k), 0, 32'h0, 0, 0, 1);
      chk($sformatf("midrst%0d.u3rvld", k), {31'b0, rvld3}, 32'h0);
      @(negedge clk);
    end
    reset = 1'b0;
    set_in(0, 32'h0, 0, 32'h0, 32'h0, 4'h0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("drop%0d.u3rvld", k), {31'b0, rvld3}, 32'h0);
      chk($sformatf("drop%0d.u0rvld", k), {31'b0, rvld0}, 32'h0);
      @(negedge clk);
    end
    set_in(1, 32'h10, 0, 32'h0, 32'h0, 4'h0);
    @(posedge clk); #1;
    check_u0("retain", 1, 32'hDEADABEF, 0, 0, 1);
    @(negedge clk);
    set_in(0, 32'h0, 0, 32'h0, 32'h0, 4'h0);
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
